// File: rtl/addr_xlate_arbiter.sv
// Address translation + read/write arbiter.
// Splits an AXI address into DRAM {ch,rk,bg,bk,row,col} fields, optionally
// hashes bank/bankgroup with low row bits, and arbitrates read vs write into
// a single output register that targets one of the per-(channel,rank) FSMs.
// Reads win by default; a waiting write is forced through after STARVE_LIMIT
// consecutive read grants.
module addr_xlate_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int CH_W         = 1,
    parameter int RK_W         = 1,
    parameter int BG_W         = 2,
    parameter int BK_W         = 2,
    parameter int ROW_W        = 16,
    parameter int COL_W        = 10,
    parameter int XOR_EN       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_valid,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_ready,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    output logic                          wr_ready,
    input  logic [2**(CH_W+RK_W)-1:0]     fsm_ready,
    output logic                          out_valid,
    output logic                          out_is_write,
    output logic [2**(CH_W+RK_W)-1:0]     out_fsm_vec,
    output logic [CH_W+RK_W-1:0]          out_fsm_idx,
    output logic [CH_W-1:0]               out_ch,
    output logic [RK_W-1:0]               out_rk,
    output logic [BG_W-1:0]               out_bg,
    output logic [BK_W-1:0]               out_bk,
    output logic [ROW_W-1:0]              out_row,
    output logic [COL_W-1:0]              out_col
);

    localparam int MEM_W   = CH_W + RK_W + BG_W + BK_W + ROW_W + COL_W;
    localparam int FSM_W   = CH_W + RK_W;
    localparam int NUM_FSM = 2**FSM_W;

    // Packed in address order, MSB first, so a plain cast performs the decode.
    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [RK_W-1:0]  rk;
        logic [BG_W-1:0]  bg;
        logic [BK_W-1:0]  bk;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } fields_t;

    function automatic fields_t decode(input logic [ADDR_W-1:0] a);
        fields_t f;
        f = fields_t'(a[MEM_W-1:0]);
        // Spread row-sequential traffic across banks/bankgroups.
        if (XOR_EN != 0) begin
            f.bk = f.bk ^ f.row[BK_W-1:0];
            f.bg = f.bg ^ f.row[BK_W+BG_W-1:BK_W];
        end
        return f;
    endfunction

    fields_t              out_f_q, out_f_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_is_write_q, out_is_write_d;
    logic [NUM_FSM-1:0]   out_vec_q, out_vec_d;
    logic [3:0]           starve_q, starve_d;

    fields_t              rd_f, wr_f;
    logic [FSM_W-1:0]     out_idx;
    logic [FSM_W-1:0]     new_idx;
    logic                 fire, slot_free, starved, grant_rd, grant_wr;

    // Handshake, arbitration and next-state for the output stage.
    always_comb begin
        rd_f      = decode(rd_addr);
        wr_f      = decode(wr_addr);
        out_idx   = {out_f_q.ch, out_f_q.rk};
        fire      = out_valid_q & fsm_ready[out_idx];
        slot_free = ~out_valid_q | fire;
        starved   = wr_valid & (starve_q == 4'(STARVE_LIMIT));
        // Readies are gated by rst so nothing is reported accepted in reset.
        grant_rd  = ~rst & slot_free & rd_valid & ~starved;
        grant_wr  = ~rst & slot_free & wr_valid & ~grant_rd;

        out_valid_d    = (out_valid_q & ~fire) | grant_rd | grant_wr;
        out_f_d        = out_f_q;
        out_is_write_d = out_is_write_q;
        out_vec_d      = fire ? '0 : out_vec_q;
        new_idx        = '0;
        if (grant_rd | grant_wr) begin
            out_f_d        = grant_wr ? wr_f : rd_f;
            out_is_write_d = grant_wr;
            new_idx        = {out_f_d.ch, out_f_d.rk};
            out_vec_d      = '0;
            out_vec_d[new_idx] = 1'b1;
        end

        // Count reads that bypass a waiting write; any gap in wr_valid resets it.
        starve_d = starve_q;
        if (!wr_valid || grant_wr)
            starve_d = '0;
        else if (grant_rd && (starve_q < 4'(STARVE_LIMIT)))
            starve_d = starve_q + 4'd1;
    end

    // Output register stage and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_is_write_q <= 1'b0;
            out_vec_q      <= '0;
            out_f_q        <= '0;
            starve_q       <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_is_write_q <= out_is_write_d;
            out_vec_q      <= out_vec_d;
            out_f_q        <= out_f_d;
            starve_q       <= starve_d;
        end
    end

    assign rd_ready     = grant_rd;
    assign wr_ready     = grant_wr;
    assign out_valid    = out_valid_q;
    assign out_is_write = out_is_write_q;
    assign out_fsm_vec  = out_vec_q;
    assign out_fsm_idx  = out_idx;
    assign out_ch       = out_f_q.ch;
    assign out_rk       = out_f_q.rk;
    assign out_bg       = out_f_q.bg;
    assign out_bk       = out_f_q.bk;
    assign out_row      = out_f_q.row;
    assign out_col      = out_f_q.col;

endmodule

// File: tb/tb_addr_xlate_arbiter.sv
// Bench for addr_xlate_arbiter: hashed (XOR_EN=1) and plain (XOR_EN=0)
// instances share one stimulus stream. A reference process predicts the
// handshake each cycle and queues accepted requests; a monitor pops and
// checks the decoded fields whenever the held request fires.
module tb_addr_xlate_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0, wr_valid = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0;
    logic [3:0]  fsm_ready = 4'hF;

    logic        h_rd_ready, h_wr_ready, h_out_valid, h_out_is_write, h_ch, h_rk;
    logic [3:0]  h_vec;
    logic [1:0]  h_idx, h_bg, h_bk;
    logic [15:0] h_row;
    logic [9:0]  h_col;
    logic        p_rd_ready, p_wr_ready, p_out_valid, p_out_is_write, p_ch, p_rk;
    logic [3:0]  p_vec;
    logic [1:0]  p_idx, p_bg, p_bk;
    logic [15:0] p_row;
    logic [9:0]  p_col;

    addr_xlate_arbiter #(.XOR_EN(1), .STARVE_LIMIT(LIMIT)) dut_h (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(h_rd_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(h_wr_ready),
        .fsm_ready(fsm_ready), .out_valid(h_out_valid), .out_is_write(h_out_is_write),
        .out_fsm_vec(h_vec), .out_fsm_idx(h_idx), .out_ch(h_ch), .out_rk(h_rk),
        .out_bg(h_bg), .out_bk(h_bk), .out_row(h_row), .out_col(h_col)
    );

    addr_xlate_arbiter #(.XOR_EN(0), .STARVE_LIMIT(LIMIT)) dut_p (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(p_rd_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(p_wr_ready),
        .fsm_ready(fsm_ready), .out_valid(p_out_valid), .out_is_write(p_out_is_write),
        .out_fsm_vec(p_vec), .out_fsm_idx(p_idx), .out_ch(p_ch), .out_rk(p_rk),
        .out_bg(p_bg), .out_bk(p_bk), .out_row(p_row), .out_col(p_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: what is held, where it goes, and how long writes have waited.
    bit m_held = 1'b0;
    int m_idx = 0;
    int m_starve = 0;

    always @(negedge clk) begin
        bit m_fire, m_free, e_rd, e_wr;
        if (rst) begin
            m_held = 1'b0;
            m_starve = 0;
            sb.delete();
        end else begin
            m_fire = m_held && fsm_ready[m_idx];
            m_free = !m_held || m_fire;
            e_rd = m_free && rd_valid && !(wr_valid && m_starve == LIMIT);
            e_wr = m_free && wr_valid && !e_rd;
            chk("h_rd_ready", 32'(h_rd_ready), 32'(e_rd));
            chk("h_wr_ready", 32'(h_wr_ready), 32'(e_wr));
            chk("p_rd_ready", 32'(p_rd_ready), 32'(e_rd));
            chk("p_wr_ready", 32'(p_wr_ready), 32'(e_wr));
            chk("h_out_valid", 32'(h_out_valid), 32'(m_held));
            chk("p_out_valid", 32'(p_out_valid), 32'(m_held));
            if (!m_held) chk("idle_vec", 32'(h_vec), 32'(0));
            if (e_rd || e_wr) begin
                exp_t e;
                e.w = e_wr;
                e.addr = e_wr ? wr_addr : rd_addr;
                sb.push_back(e);
                m_idx = int'(e.addr >> 30);
                m_held = 1'b1;
            end else if (m_fire) begin
                m_held = 1'b0;
            end
            if (!wr_valid || e_wr) m_starve = 0;
            else if (e_rd && m_starve < LIMIT) m_starve++;
        end
    end

    // Monitor: the held request is consumed when its target FSM is ready.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] row, bk, bg;
        if (!rst && h_out_valid && fsm_ready[h_idx]) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: output fired with nothing expected at %0t", $time);
            end else begin
                e = sb.pop_front();
                row = (e.addr >> 10) % 65536;
                bk  = (e.addr >> 26) % 4;
                bg  = (e.addr >> 28) % 4;
                chk("is_write", 32'(h_out_is_write), 32'(e.w));
                chk("p_is_write", 32'(p_out_is_write), 32'(e.w));
                chk("idx", 32'(h_idx), e.addr >> 30);
                chk("p_idx", 32'(p_idx), e.addr >> 30);
                chk("vec", 32'(h_vec), 32'(1) << (e.addr >> 30));
                chk("p_vec", 32'(p_vec), 32'(1) << (e.addr >> 30));
                chk("ch", 32'(h_ch), e.addr >> 31);
                chk("rk", 32'(h_rk), (e.addr >> 30) % 2);
                chk("row", 32'(h_row), row);
                chk("col", 32'(h_col), e.addr % 1024);
                chk("h_bk", 32'(h_bk), bk ^ (row % 4));
                chk("h_bg", 32'(h_bg), bg ^ ((row >> 2) % 4));
                chk("p_bk", 32'(p_bk), bk);
                chk("p_bg", 32'(p_bg), bg);
                chk("p_row", 32'(p_row), row);
                chk("p_col", 32'(p_col), e.addr % 1024);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        fsm_ready = 4'hF;
        repeat (n) step();
    endtask

    initial begin
        string exp_s;
        byte   g;

        // Reset state, with a read offered to prove readies are gated.
        rd_valid = 1'b1;
        rd_addr = 32'hC000_0000;
        #2;
        chk("rst_out_valid", 32'(h_out_valid), 32'(0));
        chk("rst_vec", 32'(h_vec), 32'(0));
        chk("rst_rd_ready", 32'(h_rd_ready), 32'(0));
        step();
        rst = 1'b0;
        idle(2);

        // Decode: top address bit selects channel 1 -> FSM 2.
        rd_valid = 1'b1;
        rd_addr = 32'h8000_0000;
        @(negedge clk);
        chk("dec_rd_ready", 32'(p_rd_ready), 32'(1));
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("dec_valid", 32'(p_out_valid), 32'(1));
        chk("dec_idx", 32'(p_idx), 32'(2));
        chk("dec_vec", 32'(p_vec), 32'(4'b0100));
        chk("dec_ch", 32'(p_ch), 32'(1));
        chk("dec_rk", 32'(p_rk), 32'(0));
        chk("dec_is_write", 32'(p_out_is_write), 32'(0));
        idle(2);

        // Hash: row=1 flips bank bit 0 on the hashed instance only.
        wr_valid = 1'b1;
        wr_addr = 32'h0000_0400;
        @(negedge clk);
        chk("hash_wr_ready", 32'(h_wr_ready), 32'(1));
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("hash_row", 32'(h_row), 32'(1));
        chk("hash_bk", 32'(h_bk), 32'(1));
        chk("hash_bg", 32'(h_bg), 32'(0));
        chk("hash_is_write", 32'(h_out_is_write), 32'(1));
        chk("plain_bk", 32'(p_bk), 32'(0));
        idle(2);

        // Backpressure: FSM 2 not ready for 3 cycles, then release.
        rd_valid = 1'b1;
        rd_addr = 32'h8000_0000;
        step();
        rd_addr = 32'h4000_1234;
        wr_valid = 1'b1;
        wr_addr = 32'h0000_0400;
        fsm_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rd_ready", 32'(h_rd_ready), 32'(0));
            chk("bp_wr_ready", 32'(h_wr_ready), 32'(0));
            chk("bp_valid", 32'(h_out_valid), 32'(1));
            chk("bp_idx", 32'(h_idx), 32'(2));
            chk("bp_col", 32'(h_col), 32'(0));
            step();
        end
        fsm_ready = 4'hF;
        @(negedge clk);
        chk("bp_fire_rd_ready", 32'(h_rd_ready), 32'(1));
        step();
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(h_out_valid), 32'(1));
        chk("bp_next_idx", 32'(h_idx), 32'(1));
        chk("bp_next_col", 32'(h_col), 32'(10'h234));
        chk("bp_next_row", 32'(h_row), 32'(4));
        idle(2);

        // Starvation: both requesters pinned high.
        exp_s = "RRRRWRRRRW";
        rd_valid = 1'b1;
        rd_addr = 32'h0000_0000;
        wr_valid = 1'b1;
        wr_addr = 32'h4000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = h_rd_ready ? "R" : (h_wr_ready ? "W" : "-");
            chk("starve_grant", 32'(g), 32'(exp_s[i]));
            step();
        end
        idle(2);

        // Reset while a request is held.
        rd_valid = 1'b1;
        rd_addr = 32'h8123_4567;
        step();
        rd_valid = 1'b0;
        fsm_ready = 4'h0;
        step();
        rst = 1'b1;
        rd_valid = 1'b1;
        rd_addr = 32'hC000_0000;
        fsm_ready = 4'hF;
        #1;
        chk("mid_rst_valid", 32'(h_out_valid), 32'(0));
        chk("mid_rst_vec", 32'(h_vec), 32'(0));
        chk("mid_rst_rd_ready", 32'(h_rd_ready), 32'(0));
        chk("mid_rst_row", 32'(h_row), 32'(0));
        chk("mid_rst_col", 32'(h_col), 32'(0));
        chk("mid_rst_ch", 32'(h_ch), 32'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rd_ready", 32'(h_rd_ready), 32'(1));
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(h_out_valid), 32'(1));
        chk("post_rst_idx", 32'(h_idx), 32'(3));
        chk("post_rst_vec", 32'(h_vec), 32'(4'b1000));
        idle(2);

        // Randomized traffic with valids that may drop without a handshake.
        for (int i = 0; i < 3000; i++) begin
            rd_valid = ($urandom % 3) != 0;
            rd_addr = $urandom;
            wr_valid = ($urandom % 3) != 0;
            wr_addr = $urandom;
            fsm_ready = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
            step();
        end
        idle(5);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
